// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES round sequencing controller for an external round core
//
// Purpose: accepts a plaintext/key pair, holds them for the round core, sequences
// the round index 0..NUM_ROUNDS with matching Rcon, then captures the core result.
// Optional feature macro: AES_CTRL_STALL_EN adds a stall input that freezes RUN.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall            (AES_CTRL_STALL_EN only) hold the round sequence while in RUN
//   start            request; accepted only in IDLE or DONE
//   data_in, key_in  plaintext and key, sampled on acceptance
//   core_out         registered state output of the round core
//   core_data        plaintext held for the core
//   core_key         key held for the core
//   first_round      round-0 (initial AddRoundKey) cycle
//   final_round      last round cycle (no MixColumns)
//   round_const      Rcon for the current round
//   round_cnt        current round index
//   core_en          core advances one round at this edge
//   busy             RUN or CAPTURE
//   done             one-cycle pulse, ciphertext valid
//   ciphertext       captured result
module aes_round_ctrl #(
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = KEY_W / 32 + 6
) (
  input  logic             clk,
  input  logic             rst,
`ifdef AES_CTRL_STALL_EN
  input  logic             stall,
`endif
  input  logic             start,
  input  logic [127:0]     data_in,
  input  logic [KEY_W-1:0] key_in,
  input  logic [127:0]     core_out,
  output logic [127:0]     core_data,
  output logic [KEY_W-1:0] core_key,
  output logic             first_round,
  output logic             final_round,
  output logic [7:0]       round_const,
  output logic [3:0]       round_cnt,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic [127:0]     ciphertext
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_DONE} state_e;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [127:0]     data_q, data_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [127:0]     ct_q, ct_d;
  logic             stall_w;
  logic             advance;

`ifdef AES_CTRL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign advance = (state_q == S_RUN) && !stall_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcon_d  = rcon_q;
    data_d  = data_q;
    key_d   = key_q;
    ct_d    = ct_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          data_d  = data_in;
          key_d   = key_in;
          cnt_d   = 4'd0;
          rcon_d  = 8'h01;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (advance) begin
          if (cnt_q == LAST_RND) begin
            // Index stays at the last round so it reads back after completion.
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q + 4'd1;
            // Round 0 is the plain AddRoundKey, so round 1 reuses Rcon=01.
            if (cnt_q == 4'd0) begin
              rcon_d = 8'h01;
            end else begin
              rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
            end
          end
        end
      end
      S_CAPTURE: begin
        ct_d    = core_out;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rcon_q  <= 8'h01;
      data_q  <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      data_q  <= data_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  assign core_en     = advance;
  assign first_round = (state_q == S_RUN) && (cnt_q == 4'd0);
  assign final_round = (state_q == S_RUN) && (cnt_q == LAST_RND);
  assign busy        = (state_q == S_RUN) || (state_q == S_CAPTURE);
  assign done        = (state_q == S_DONE);
  assign round_cnt   = cnt_q;
  assign round_const = rcon_q;
  assign core_data   = data_q;
  assign core_key    = key_q;
  assign ciphertext  = ct_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl (128- and 256-bit keys)
//
// Purpose: drives two controllers (KEY_W=128 with an AES-128 round core model,
// KEY_W=256 with a fixed core output) and scoreboards ciphertext and latency.
// Build with AES_CTRL_STALL_EN defined to exercise the stall input.
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst;
  logic         start_a, start_b;
  logic [127:0] data_in;
  logic [127:0] key_a;
  logic [255:0] key_b;
  logic [127:0] core_out_a, core_out_b;
  logic [127:0] core_data_a, core_data_b;
  logic [127:0] core_key_a;
  logic [255:0] core_key_b;
  logic         first_a, final_a, core_en_a, busy_a, done_a;
  logic         first_b, final_b, core_en_b, busy_b, done_b;
  logic [7:0]   rcon_a, rcon_b;
  logic [3:0]   cnt_a, cnt_b;
  logic [127:0] ct_a, ct_b;
`ifdef AES_CTRL_STALL_EN
  logic         stall_a;
`endif

  localparam logic [127:0] KAT_CT  = 128'h3F5B8CC9EA855A0AFA7347D23E8D664E;
  localparam logic [127:0] CORE_B  = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic [7:0] rc_tab [0:14] = '{8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

  aes_round_ctrl #(.KEY_W(128)) u_dut_a (
    .clk(clk), .rst(rst),
`ifdef AES_CTRL_STALL_EN
    .stall(stall_a),
`endif
    .start(start_a), .data_in(data_in), .key_in(key_a), .core_out(core_out_a),
    .core_data(core_data_a), .core_key(core_key_a), .first_round(first_a),
    .final_round(final_a), .round_const(rcon_a), .round_cnt(cnt_a), .core_en(core_en_a),
    .busy(busy_a), .done(done_a), .ciphertext(ct_a)
  );

  aes_round_ctrl #(.KEY_W(256)) u_dut_b (
    .clk(clk), .rst(rst),
`ifdef AES_CTRL_STALL_EN
    .stall(1'b0),
`endif
    .start(start_b), .data_in(data_in), .key_in(key_b), .core_out(core_out_b),
    .core_data(core_data_b), .core_key(core_key_b), .first_round(first_b),
    .final_round(final_b), .round_const(rcon_b), .round_cnt(cnt_b), .core_en(core_en_b),
    .busy(busy_b), .done(done_b), .ciphertext(ct_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- AES-128 helpers ----------------
  logic [7:0] sbox [0:255];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  initial begin
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] a [16];
    logic [7:0] t [16];
    logic [7:0] m [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) t[c*4+w] = a[((c + w) % 4)*4 + w];
    for (int c = 0; c < 4; c++) begin
      m[c*4+0] = xt(t[c*4]) ^ xt(t[c*4+1]) ^ t[c*4+1] ^ t[c*4+2] ^ t[c*4+3];
      m[c*4+1] = t[c*4] ^ xt(t[c*4+1]) ^ xt(t[c*4+2]) ^ t[c*4+2] ^ t[c*4+3];
      m[c*4+2] = t[c*4] ^ t[c*4+1] ^ xt(t[c*4+2]) ^ xt(t[c*4+3]) ^ t[c*4+3];
      m[c*4+3] = xt(t[c*4]) ^ t[c*4] ^ t[c*4+1] ^ t[c*4+2] ^ xt(t[c*4+3]);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? t[i] : m[i];
    return r ^ rk;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] rot, sub, n0, n1, n2, n3;
    rot = {rk[23:0], rk[31:24]};
    sub = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]} ^ {rc, 24'h0};
    n0 = rk[127:96] ^ sub;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes128_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s, rk;
    logic [7:0] rc;
    s  = pt ^ k;
    rk = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = key_step(rk, rc);
      s  = aes_round(s, rk, r == 10);
      rc = xt(rc);
    end
    return s;
  endfunction

  // Round core model driven by the controller's sequencing outputs.
  logic [127:0] st_a, rk_a;
  always @(posedge clk) begin
    if (core_en_a) begin
      if (first_a) begin
        st_a <= core_data_a ^ core_key_a;
        rk_a <= core_key_a;
      end else begin
        st_a <= aes_round(st_a, key_step(rk_a, rcon_a), final_a);
        rk_a <= key_step(rk_a, rcon_a);
      end
    end
  end
  assign core_out_a = st_a;
  assign core_out_b = CORE_B;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] ct;
    int           issue;
    int           lat;
  } sb_t;

  sb_t sb_a[$];
  sb_t sb_b[$];

  always @(negedge clk) begin
    sb_t e;
    if (done_a) begin
      if (sb_a.size() == 0) begin
        chk("done_a_unexpected", 1, 0);
      end else begin
        e = sb_a.pop_front();
        chk("ct_a", ct_a, e.ct);
        chk("lat_a", cyc - e.issue + 1, e.lat);
      end
    end
    if (done_b) begin
      if (sb_b.size() == 0) begin
        chk("done_b_unexpected", 1, 0);
      end else begin
        e = sb_b.pop_front();
        chk("ct_b", ct_b, e.ct);
        chk("lat_b", cyc - e.issue + 1, e.lat);
      end
    end
  end

  task automatic issue_a(input logic [127:0] d, input logic [127:0] k,
                         input logic [127:0] exp, input int lat);
    sb_t e;
    start_a = 1'b1;
    data_in = d;
    key_a   = k;
    e.ct    = exp;
    e.issue = cyc + 1;
    e.lat   = lat;
    sb_a.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_a.size() != 0 || sb_b.size() != 0) begin
      chk("drain_timeout", 1, 0);
      sb_a.delete();
      sb_b.delete();
    end
  endtask

  task automatic wait_done_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_a_timeout", 1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] d, k;
    bit ok;
    sb_t e;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    data_in = '0;
    key_a = '0;
    key_b = '0;
`ifdef AES_CTRL_STALL_EN
    stall_a = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_first", first_a, 0);
    chk("rst_final", final_a, 0);
    chk("rst_core_en", core_en_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_rcon", rcon_a, 8'h01);
    chk("rst_ct", ct_a, 0);
    chk("rst_core_data", core_data_a, 0);
    chk("rst_core_key", core_key_a, 0);
    chk("rst_core_key_b", core_key_b, 0);
    chk("rst_rcon_b", rcon_b, 8'h01);
    rst = 1'b0;

    // Known-answer vector with full per-round walk
    @(negedge clk);
    issue_a({128{1'b1}}, 128'h0, KAT_CT, 13);
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("cnt_a c=%0d", c), cnt_a, c);
      chk($sformatf("rcon_a c=%0d", c), rcon_a, rc_tab[c]);
      chk($sformatf("first_a c=%0d", c), first_a, c == 0);
      chk($sformatf("final_a c=%0d", c), final_a, c == 10);
      chk($sformatf("core_en_a c=%0d", c), core_en_a, 1);
      chk($sformatf("busy_a c=%0d", c), busy_a, 1);
      @(negedge clk);
    end
    chk("capture_busy", busy_a, 1);
    chk("capture_core_en", core_en_a, 0);
    chk("capture_final", final_a, 0);
    @(negedge clk);
    chk("done_cycle_done", done_a, 1);
    chk("done_cycle_busy", busy_a, 0);
    drain(5);
    @(negedge clk);
    chk("idle_done", done_a, 0);
    chk("idle_hold_cnt", cnt_a, 10);
    chk("idle_hold_rcon", rcon_a, 8'h36);
    chk("idle_hold_ct", ct_a, KAT_CT);

    // Random vectors checked against an independent reference
    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      issue_a(d, k, aes128_ref(d, k), 13);
      @(negedge clk);
      start_a = 1'b0;
      data_in = ~d;
      key_a = ~k;
      chk("hold_data", core_data_a, d);
      chk("hold_key", core_key_a, k);
      drain(20);
    end

    // start during RUN is ignored
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    issue_a(d, k, aes128_ref(d, k), 13);
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("ign_cnt5", cnt_a, 5);
    start_a = 1'b1;
    data_in = ~d;
    key_a = ~k;
    @(negedge clk);
    start_a = 1'b0;
    chk("ign_data", core_data_a, d);
    chk("ign_cnt6", cnt_a, 6);
    drain(20);
    repeat (20) @(negedge clk);

    // start held in DONE -> back-to-back with no IDLE cycle
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    issue_a(d, k, aes128_ref(d, k), 13);
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(ok);
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    issue_a(d, k, aes128_ref(d, k), 13);
    @(negedge clk);
    start_a = 1'b0;
    chk("b2b_busy", busy_a, 1);
    chk("b2b_cnt", cnt_a, 0);
    chk("b2b_first", first_a, 1);
    drain(20);

    // Reset mid-operation, with start also high
    @(negedge clk);
    issue_a({$urandom, $urandom, $urandom, $urandom}, 128'h1, 128'h0, 13);
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_cnt6", cnt_a, 6);
    rst = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    sb_a.delete();
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_ct", ct_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_rcon", rcon_a, 8'h01);
    rst = 1'b0;
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", busy_a, 0);

    // 256-bit key: 14 rounds, latency 17
    @(negedge clk);
    start_b = 1'b1;
    key_b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    data_in = {$urandom, $urandom, $urandom, $urandom};
    e.ct = CORE_B;
    e.issue = cyc + 1;
    e.lat = 17;
    sb_b.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      chk($sformatf("cnt_b c=%0d", c), cnt_b, c);
      chk($sformatf("rcon_b c=%0d", c), rcon_b, rc_tab[c]);
      chk($sformatf("final_b c=%0d", c), final_b, c == 14);
      chk($sformatf("first_b c=%0d", c), first_b, c == 0);
      @(negedge clk);
    end
    drain(10);

`ifdef AES_CTRL_STALL_EN
    // Stall for three RUN cycles at c=4
    @(negedge clk);
    issue_a({128{1'b1}}, 128'h0, KAT_CT, 16);
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    stall_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_cnt", cnt_a, 4);
      chk("stall_core_en", core_en_a, 0);
      chk("stall_rcon", rcon_a, 8'h08);
      chk("stall_busy", busy_a, 1);
      @(negedge clk);
    end
    stall_a = 1'b0;
    chk("unstall_cnt", cnt_a, 4);
    chk("unstall_core_en", core_en_a, 1);
    drain(20);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_a.size() + sb_b.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter KEY_W, default 128, meaning key width in bits; legal values 128, 192 and 256.
REQ-002 Parameter NUM_ROUNDS, default KEY_W/32+6, meaning the round count (10, 12 or 14); it is derived from KEY_W and SHALL NOT be overridden.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to encrypt data_in with key_in.
REQ-006 data_in  input  128  plaintext block, sampled when start is accepted.
REQ-007 key_in  input  KEY_W  cipher key, sampled when start is accepted.
REQ-008 core_out  input  128  registered state output of the round core.
REQ-009 core_data  output  128  plaintext held for the core for the whole operation.
REQ-010 core_key  output  KEY_W  key held for the core for the whole operation.
REQ-011 first_round  output  1  high in the round-0 (initial AddRoundKey) cycle.
REQ-012 final_round  output  1  high in the last round cycle (no MixColumns).
REQ-013 round_const  output  8  Rcon value for the current round.
REQ-014 round_cnt  output  4  current round index c.
REQ-015 core_en  output  1  core advances one round at this clock edge.
REQ-016 busy  output  1  operation in progress.
REQ-017 done  output  1  one-cycle pulse; ciphertext valid.
REQ-018 ciphertext  output  128  captured result, held until the next capture or reset.

Function
REQ-019 The FSM SHALL have these states and transitions: IDLE->RUN on accepted start; RUN->CAPTURE after the c=NUM_ROUNDS cycle; CAPTURE->DONE; DONE->IDLE, or DONE->RUN if start is high.
REQ-020 start SHALL be accepted only in IDLE or DONE; start in RUN or CAPTURE SHALL be ignored and not queued.
REQ-021 On acceptance, data_in and key_in SHALL be registered into core_data and core_key, and c SHALL be set to 0.
REQ-022 In RUN, c SHALL increment by 1 per core_en cycle, counting 0..NUM_ROUNDS.
REQ-023 In RUN, first_round SHALL equal (c==0) and final_round SHALL equal (c==NUM_ROUNDS); both SHALL be 0 in all other states.
REQ-024 round_const SHALL follow this schedule: 8'h01 at c=0 and c=1; then xtime of the previous value per advance (shift left 1, XOR 8'h1B if bit 7 was set).
REQ-025 The resulting round_const sequence for c=1..14 SHALL be 01 02 04 08 10 20 40 80 1B 36 6C D8 AB 4D.
REQ-026 In CAPTURE, ciphertext SHALL load core_out at the closing edge.
REQ-027 done SHALL be high for exactly the DONE cycle.
REQ-028 busy SHALL be 1 in RUN and CAPTURE and 0 in IDLE and DONE.
REQ-029 Latency SHALL be NUM_ROUNDS+3 cycles from the edge sampling start to the cycle with done=1 (13/15/17 cycles), with no stalls.
REQ-030 core_en SHALL be 1 in RUN (subject to REQ-035) and 0 otherwise.
REQ-031 round_cnt and round_const SHALL hold their values outside RUN.

Reset
REQ-032 While rst=1 at a clock edge, the FSM SHALL go to IDLE, including mid-operation, and the in-flight result SHALL be discarded with no done.
REQ-033 Reset values SHALL be: busy=0, done=0, first_round=0, final_round=0, core_en=0, round_cnt=0, round_const=8'h01, ciphertext=0, core_data=0, core_key=0.
REQ-034 rst SHALL override start in the same cycle.

Configuration
REQ-035 With AES_CTRL_STALL_EN defined, an input stall (1 bit) SHALL exist; stall=1 in RUN forces core_en=0 and holds c, round_const, first_round and final_round, and latency grows by the number of stalled RUN cycles; stall has no effect in other states.
REQ-036 Without AES_CTRL_STALL_EN, no stall port SHALL exist and core_en SHALL equal (state==RUN).

Verification
REQ-037 KEY_W=128, key=0, data_in=all-FF, core model attached -> done after 13 cycles and ciphertext = 3F5B8CC9EA855A0AFA7347D23E8D664E.
REQ-038 KEY_W=128 -> round_const at c=1..10 equals 01,02,04,08,10,20,40,80,1B,36; first_round only at c=0; final_round only at c=10.
REQ-039 KEY_W=256 -> final_round at c=14, round_const=4D at c=14, done 17 cycles after start.
REQ-040 start pulsed at c=5 -> ignored, single done; start held high in the DONE cycle -> next RUN starts with no IDLE cycle.
REQ-041 rst asserted at c=6 -> next cycle busy=0, round_cnt=0, ciphertext=0, and no done thereafter.
REQ-042 AES_CTRL_STALL_EN, stall high for 3 cycles at c=4 -> c holds at 4, core_en=0, done at 16 cycles, same ciphertext as REQ-037.
